// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word RAM with byte-enable stores, extended multi-cycle loads and pipeline stall (macro DMEM_MISALIGN_TRAP_EN enables misalign trap; ports clk, reset(async active-low), memreadM, memwriteM, widthM, aluoutM, writedataM -> readdataM, stallM, misalignM)
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  widthM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   idx_q, idx;
  logic [1:0]      off_q, off;
  logic [2:0]      width_q, w;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            idle, req, trap, wr, rd, ld, unused;
  logic [31:0]     word, wdat, ext;
  logic [15:0]     h16;
  logic [7:0]      b8;
  logic [3:0]      be;
  assign unused = ^aluoutM[31:AW+2];
  assign idle = reset && state_q == IDLE;
  assign req  = idle && (memreadM || memwriteM);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = req && (widthM[1] ? |aluoutM[1:0] : widthM[0] & aluoutM[0]);
`else
  assign trap = 1'b0;
`endif
  assign misalignM = trap;
  assign wr     = req && memwriteM && !trap;
  assign rd     = req && !memwriteM && !trap;
  assign stallM = rd || (reset && state_q == RD_WAIT);
  assign ld     = (rd && LAT == 1) || (state_q == RD_WAIT && cnt_q == CW'(1));
  assign idx  = idle ? aluoutM[AW+1:2] : idx_q;
  assign off  = idle ? aluoutM[1:0] : off_q;
  assign w    = idle ? widthM : width_q;
  assign word = mem[idx];
  assign b8   = word[{off, 3'b000} +: 8];
  assign h16  = off[1] ? word[31:16] : word[15:0];
  assign ext  = w[1] ? word : w[0] ? {{16{~w[2] & h16[15]}}, h16} : {{24{~w[2] & b8[7]}}, b8};
  assign be   = widthM[1] ? 4'hF : widthM[0] ? (aluoutM[1] ? 4'hC : 4'h3) : 4'b0001 << aluoutM[1:0];
  assign wdat = widthM[1] ? writedataM : widthM[0] ? {2{writedataM[15:0]}} : {4{writedataM[7:0]}};
  always_ff @(posedge clk)
    if (wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[aluoutM[AW+1:2]][8*b +: 8] <= wdat[8*b +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      width_q   <= '0;
      readdataM <= '0;
    end else begin
      if (ld) readdataM <= ext;
      case (state_q)
        IDLE: if (rd) begin
          cnt_q   <= CW'(LAT - 1);
          idx_q   <= aluoutM[AW+1:2];
          off_q   <= aluoutM[1:0];
          width_q <= widthM;
          state_q <= LAT == 1 ? DONE : RD_WAIT;
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed bench for data_mem_ctrl against a byte-level memory model
module tb_data_mem_ctrl;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  logic        clk = 0, reset = 0, memreadM = 0, memwriteM = 0;
  logic [2:0]  widthM = 0;
  logic [31:0] aluoutM = 0, writedataM = 0;
  logic [31:0] readdataM;
  logic        stallM, misalignM;
  int          checks = 0, failures = 0;
  logic [7:0]  bm [DEPTH*4];
  logic [31:0] last_rd = 0, got;
  logic [2:0]  lw [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  always #5 clk = ~clk;
  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM), .widthM(widthM),
    .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM), .stallM(stallM), .misalignM(misalignM)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction
  function automatic bit bad(input logic [31:0] a, input logic [2:0] f);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (a % size_of(f)) != 0;
`else
    return 0;
`endif
  endfunction
  function automatic int base_of(input logic [31:0] a, input logic [2:0] f);
    int n = size_of(f);
    return int'(a % (DEPTH * 4)) / n * n;
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    int n = size_of(f);
    int base = base_of(a, f);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(bm[base+i]) << (8 * i));
    if (n < 4 && f < 3 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
    return v;
  endfunction
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input bit both = 0);
    aluoutM = a; writedataM = d; widthM = f; memwriteM = 1; memreadM = both;
    #1;
    check("st_stall", stallM, 0);
    check("st_misalign", misalignM, bad(a, f));
    @(posedge clk); #1;
    memwriteM = 0; memreadM = 0;
    if (!bad(a, f)) begin
      int base = base_of(a, f);
      for (int i = 0; i < size_of(f); i++) bm[base+i] = d[8*i +: 8];
    end
    check("st_hold", readdataM, last_rd);
  endtask
  task automatic load(input logic [31:0] a, input logic [2:0] f, output logic [31:0] res);
    int n = 0;
    logic [31:0] exp;
    aluoutM = a; widthM = f; memreadM = 1; memwriteM = 0;
    #1;
    check("ld_misalign", misalignM, bad(a, f));
    if (bad(a, f)) begin
      check("ld_trap_stall", stallM, 0);
      @(posedge clk); #1;
      memreadM = 0;
      check("ld_trap_hold", readdataM, last_rd);
      res = readdataM;
      return;
    end
    exp = model_load(a, f);
    while (stallM && n < LAT + 4) begin
      n++;
      @(posedge clk); #1;
    end
    check("ld_stall_cycles", n, LAT);
    check("ld_data", readdataM, exp);
    res = readdataM;
    last_rd = exp;
    memreadM = 0;
    @(posedge clk); #1;
    check("ld_after_stall", stallM, 0);
    check("ld_after_hold", readdataM, last_rd);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    memreadM = 1;
    #1;
    check("rst_rd", readdataM, 0);
    check("rst_stall", stallM, 0);
    check("rst_misalign", misalignM, 0);
    repeat (2) @(posedge clk);
    #1;
    memreadM = 0;
    reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) store(32'(i * 4), $urandom, 3'd2);
    store(32'h10, 32'hDEADBEEF, 3'd2);
    load(32'h10, 3'd2, got);  check("t1_lw", got, 32'hDEADBEEF);
    store(32'h11, 32'h80, 3'd0);
    load(32'h10, 3'd2, got);  check("t2_lw", got, 32'hDEAD80EF);
    load(32'h11, 3'd0, got);  check("t2_lb", got, 32'hFFFFFF80);
    load(32'h11, 3'd4, got);  check("t2_lbu", got, 32'h00000080);
    store(32'h12, 32'h8234, 3'd1);
    load(32'h12, 3'd1, got);  check("t3_lh", got, 32'hFFFF8234);
    load(32'h12, 3'd5, got);  check("t3_lhu", got, 32'h00008234);
    load(32'h10, 3'd2, got);  check("t3_lw", got, 32'h823480EF);
    load(32'h13, 3'd2, got);
`ifndef DMEM_MISALIGN_TRAP_EN
    check("t4_lw_trunc", got, 32'h823480EF);
`endif
    load(32'h10, 3'd2, got);
    load(32'h14, 3'd2, got);
    load(32'h1010, 3'd2, got); check("t6_alias", got, 32'h823480EF);
    store(32'h2014, 32'h12345678, 3'd2);
    load(32'h14, 3'd2, got);  check("t6_alias_st", got, 32'h12345678);
    store(32'h18, 32'hCAFEF00D, 3'd2, 1);
    load(32'h18, 3'd2, got);  check("both_st", got, 32'hCAFEF00D);
    aluoutM = 32'h10; widthM = 3'd2; memreadM = 1;
    #1;
    check("t5_req_stall", stallM, 1);
    @(posedge clk); #1;
    check("t5_wait_stall", stallM, 1);
    reset = 0;
    #1;
    check("t5_abort_stall", stallM, 0);
    check("t5_abort_rd", readdataM, 0);
    last_rd = 0;
    memreadM = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    load(32'h10, 3'd2, got);  check("t5_after", got, 32'h823480EF);
    repeat (300) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: store(a, $urandom, 3'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        1: load(a, lw[$urandom_range(0, 4)], got);
        default: begin
          @(posedge clk); #1;
          check("idle_hold", readdataM, last_rd);
          check("idle_stall", stallM, 0);
        end
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
